multi_gate_lot: RTL and testbench

Parametrised parking-lot occupancy controller for N_GATES independent gates, each watched by a two-beam sensor pair (outer beam a, inner beam b). Per gate it synchronises the raw beams, recognises complete vehicle entries and exits, and rejects pedestrians, partial passages and reversals. A shared occupancy counter merges same-cycle events from all gates and saturates at 0 and CAPACITY. It drives BCD digits plus full/clear/error flags to the board display logic.

---
 rtl/lot_pkg.sv | 37 +++
 rtl/multi_gate_lot_if.sv | 39 +++
 rtl/lot_gate_fsm.sv | 118 +++++++++++
 rtl/multi_gate_lot.sv | 88 ++++++++
 tb/tb_multi_gate_lot.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lot_pkg.sv
// Shared types and helpers for the multi-gate parking-lot controller.
//   gate_state_t : per-gate passage recogniser states
//   to_bcd()     : binary occupancy -> {hundreds, tens, ones}
//   MAX_GATES / MAX_CAPACITY : upper limits for the lot parameters
package lot_pkg;

  localparam int MAX_GATES    = 8;
  localparam int MAX_CAPACITY = 999;

  // Widths sized for the largest legal lot.
  localparam int EVW   = $clog2(MAX_GATES + 1);
  localparam int BCD_W = $clog2(MAX_CAPACITY + 1);

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A
  } gate_state_t;

  // Shift-add-3 conversion; returns {hundreds, tens, ones}.
  function automatic logic [11:0] to_bcd(input logic [BCD_W-1:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = BCD_W - 1; i >= 0; i--) begin
      if (bcd[3:0] > 4'd4)  bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4] > 4'd4)  bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/multi_gate_lot_if.sv
// Sensor / display bundle of the parking-lot controller.
//   a_raw, b_raw     : raw outer / inner beams per gate (1 = blocked)
//   count            : occupancy
//   ones/tens/hundreds : BCD of count
//   full, clear      : count == CAPACITY / count == 0
//   inc_evt, dec_evt : one-cycle pulses per completed entry / exit per gate
//   err_over, err_under : sticky drop flags
// master = sensor side (drives beams), slave = controller.
interface multi_gate_lot_if #(
  parameter int N_GATES  = 2,
  parameter int CAPACITY = 25
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic [N_GATES-1:0] a_raw;
  logic [N_GATES-1:0] b_raw;
  logic [CW-1:0]      count;
  logic [3:0]         ones;
  logic [3:0]         tens;
  logic [3:0]         hundreds;
  logic               full;
  logic               clear;
  logic [N_GATES-1:0] inc_evt;
  logic [N_GATES-1:0] dec_evt;
  logic               err_over;
  logic               err_under;

  modport master (
    output a_raw, b_raw,
    input  count, ones, tens, hundreds, full, clear,
    input  inc_evt, dec_evt, err_over, err_under
  );

  modport slave (
    input  a_raw, b_raw,
    output count, ones, tens, hundreds, full, clear,
    output inc_evt, dec_evt, err_over, err_under
  );
endinterface

// File: rtl/lot_gate_fsm.sv
// One gate: two-flop synchroniser on each beam plus the passage recogniser.
//   clk, reset : system clock, synchronous active-high reset
//   a_raw      : outer beam (asynchronous)
//   b_raw      : inner beam (asynchronous)
//   inc_evt    : registered one-cycle pulse on a completed entry
//   dec_evt    : registered one-cycle pulse on a completed exit
module lot_gate_fsm
  import lot_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic inc_evt,
  output logic dec_evt
);

  // Bit 0 is the first stage, bit 1 the stage the FSM consumes.
  logic [1:0] a_sync_reg;
  logic [1:0] b_sync_reg;
  logic [1:0] ab;

  gate_state_t state_reg;
  logic        inc_evt_reg;
  logic        dec_evt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_reg <= '0;
      b_sync_reg <= '0;
    end else begin
      a_sync_reg <= {a_sync_reg[0], a_raw};
      b_sync_reg <= {b_sync_reg[0], b_raw};
    end
  end

  assign ab = {a_sync_reg[1], b_sync_reg[1]};

  // Entry path a -> ab -> b -> clear, exit path is the mirror image.
  // Anything out of order falls back to IDLE without an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      inc_evt_reg <= 1'b0;
      dec_evt_reg <= 1'b0;
    end else begin
      inc_evt_reg <= 1'b0;
      dec_evt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // 11 from IDLE has no known direction and is ignored.
          case (ab)
            2'b10:   state_reg <= EN_A;
            2'b01:   state_reg <= EX_B;
            default: state_reg <= IDLE;
          endcase
        end
        EN_A: begin
          case (ab)
            2'b11:   state_reg <= EN_AB;
            2'b10:   state_reg <= EN_A;
            default: state_reg <= IDLE;   // backed out or no overlap
          endcase
        end
        EN_AB: begin
          case (ab)
            2'b01:   state_reg <= EN_B;
            2'b10:   state_reg <= EN_A;
            2'b00:   state_reg <= IDLE;
            default: state_reg <= EN_AB;
          endcase
        end
        EN_B: begin
          case (ab)
            2'b00: begin
              state_reg   <= IDLE;
              inc_evt_reg <= 1'b1;
            end
            2'b11:   state_reg <= EN_AB;
            2'b01:   state_reg <= EN_B;
            default: state_reg <= IDLE;
          endcase
        end
        EX_B: begin
          case (ab)
            2'b11:   state_reg <= EX_BA;
            2'b01:   state_reg <= EX_B;
            default: state_reg <= IDLE;
          endcase
        end
        EX_BA: begin
          case (ab)
            2'b10:   state_reg <= EX_A;
            2'b01:   state_reg <= EX_B;
            2'b00:   state_reg <= IDLE;
            default: state_reg <= EX_BA;
          endcase
        end
        EX_A: begin
          case (ab)
            2'b00: begin
              state_reg   <= IDLE;
              dec_evt_reg <= 1'b1;
            end
            2'b11:   state_reg <= EX_BA;
            2'b10:   state_reg <= EX_A;
            default: state_reg <= IDLE;
          endcase
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign inc_evt = inc_evt_reg;
  assign dec_evt = dec_evt_reg;

endmodule

// File: rtl/multi_gate_lot.sv
// Parking-lot occupancy controller for N_GATES two-beam gates.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of multi_gate_lot_if (beams in; count, BCD,
//                full/clear, per-gate event pulses, sticky errors out)
// Events from all gates in one cycle are merged into a single signed
// update so simultaneous entries and exits cancel before saturation.
module multi_gate_lot
  import lot_pkg::*;
#(
  parameter int N_GATES  = 2,
  parameter int CAPACITY = 25
) (
  input  logic                clk,
  input  logic                reset,
  multi_gate_lot_if.slave     bus
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int SW = CW + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [N_GATES-1:0] inc_evt;
  logic [N_GATES-1:0] dec_evt;
  logic [EVW-1:0]     n_inc;
  logic [EVW-1:0]     n_dec;
  logic signed [SW-1:0] next_s;

  logic [CW-1:0] count_reg;
  logic          err_over_reg;
  logic          err_under_reg;
  logic [11:0]   bcd;

  genvar gi;
  generate
    for (gi = 0; gi < N_GATES; gi++) begin : g_gate
      lot_gate_fsm u_fsm (
        .clk     (clk),
        .reset   (reset),
        .a_raw   (bus.a_raw[gi]),
        .b_raw   (bus.b_raw[gi]),
        .inc_evt (inc_evt[gi]),
        .dec_evt (dec_evt[gi])
      );
    end
  endgenerate

  always_comb begin
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < N_GATES; i++) begin
      n_inc = n_inc + EVW'(inc_evt[i]);
      n_dec = n_dec + EVW'(dec_evt[i]);
    end
  end

  assign next_s = signed'(SW'(count_reg)) + signed'(SW'(n_inc))
                - signed'(SW'(n_dec));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      err_over_reg  <= 1'b0;
      err_under_reg <= 1'b0;
    end else if (next_s > CAP_S) begin
      count_reg    <= CW'(CAPACITY);
      err_over_reg <= 1'b1;
    end else if (next_s < 0) begin
      count_reg     <= '0;
      err_under_reg <= 1'b1;
    end else begin
      count_reg <= next_s[CW-1:0];
    end
  end

  assign bcd = to_bcd(BCD_W'(count_reg));

  assign bus.count     = count_reg;
  assign bus.ones      = bcd[3:0];
  assign bus.tens      = bcd[7:4];
  assign bus.hundreds  = bcd[11:8];
  assign bus.full      = (count_reg == CW'(CAPACITY));
  assign bus.clear     = (count_reg == '0);
  assign bus.inc_evt   = inc_evt;
  assign bus.dec_evt   = dec_evt;
  assign bus.err_over  = err_over_reg;
  assign bus.err_under = err_under_reg;

endmodule

// File: tb/tb_multi_gate_lot.sv
// Directed bench for multi_gate_lot: a CAPACITY=5 lot and a CAPACITY=123
// lot, both with two gates. Expected gate events go into a scoreboard
// queue when a passage's last sensor step is driven; a negedge monitor
// pops and compares them against the pulses the controllers emit.
module tb_multi_gate_lot;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic reset;
  int   cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  multi_gate_lot_if #(.N_GATES(2), .CAPACITY(5))   if5 ();
  multi_gate_lot_if #(.N_GATES(2), .CAPACITY(123)) if123 ();

  multi_gate_lot #(.N_GATES(2), .CAPACITY(5)) dut5 (
    .clk   (CLOCK_50),
    .reset (reset),
    .bus   (if5.slave)
  );

  multi_gate_lot #(.N_GATES(2), .CAPACITY(123)) dut123 (
    .clk   (CLOCK_50),
    .reset (reset),
    .bus   (if123.slave)
  );

  typedef struct {
    int due;
    int dut;
    int gate;
    bit is_inc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
    $display("[%0d] check %s observed %0d expected %0d", cyc, tag, obs, expv);
  endtask

  function automatic bit pulse_of(input int d, input int g, input bit is_inc);
    logic [1:0] v;
    if (d == 0) v = is_inc ? if5.inc_evt : if5.dec_evt;
    else        v = is_inc ? if123.inc_evt : if123.dec_evt;
    return v[g] === 1'b1;
  endfunction

  // Event monitor: every observed pulse must match a queued expectation
  // on the expected cycle; expectations that expire are reported missing.
  always @(negedge CLOCK_50) begin
    for (int d = 0; d < 2; d++) begin
      for (int g = 0; g < 2; g++) begin
        for (int k = 0; k < 2; k++) begin
          if (pulse_of(d, g, k[0])) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].dut == d && sb[i].gate == g && sb[i].is_inc == k[0])
                idx = i;
            chk($sformatf("evt_expected d%0d g%0d %s", d, g, k ? "inc" : "dec"),
                32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
              chk($sformatf("evt_cycle d%0d g%0d %s", d, g, k ? "inc" : "dec"),
                  cyc, sb[idx].due);
              sb.delete(idx);
            end
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        chk($sformatf("evt_missing d%0d g%0d %s", sb[i].dut, sb[i].gate,
                      sb[i].is_inc ? "inc" : "dec"), cyc, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic set_raw(input int d, input logic [1:0] a, input logic [1:0] b);
    @(negedge CLOCK_50);
    if (d == 0) begin
      if5.a_raw = a;
      if5.b_raw = b;
    end else begin
      if123.a_raw = a;
      if123.b_raw = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Complete entries on gates in ent, complete exits on gates in ext,
  // all stepping together.
  task automatic passage(input int d, input logic [1:0] ent, input logic [1:0] ext);
    logic [3:0] pa;
    logic [3:0] pb;
    pa = 4'b1100;
    pb = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] a;
      logic [1:0] b;
      for (int g = 0; g < 2; g++) begin
        a[g] = (ent[g] & pa[3-s]) | (ext[g] & pb[3-s]);
        b[g] = (ent[g] & pb[3-s]) | (ext[g] & pa[3-s]);
      end
      set_raw(d, a, b);
    end
    for (int g = 0; g < 2; g++) begin
      if (ent[g]) sb.push_back('{cyc + 3, d, g, 1'b1});
      if (ext[g]) sb.push_back('{cyc + 3, d, g, 1'b0});
    end
    $display("[%0d] drive dut%0d passage entry=%b exit=%b", cyc, d, ent, ext);
  endtask

  // Arbitrary (a,b) steps on gate 0, first pair in the top bits.
  task automatic seq_g0(input int d, input int n, input logic [11:0] pairs, input bit exp_inc);
    for (int s = 0; s < n; s++)
      set_raw(d, {1'b0, pairs[11-2*s]}, {1'b0, pairs[10-2*s]});
    if (exp_inc) sb.push_back('{cyc + 3, d, 0, 1'b1});
    $display("[%0d] drive dut%0d gate0 %0d steps %b", cyc, d, n, pairs);
  endtask

  task automatic chk_state(input string tag, input int d, input int cnt,
                           input bit f, input bit c, input bit ov, input bit un);
    if (d == 0) begin
      chk({tag, " count"},     32'(if5.count),     cnt);
      chk({tag, " full"},      32'(if5.full),      32'(f));
      chk({tag, " clear"},     32'(if5.clear),     32'(c));
      chk({tag, " err_over"},  32'(if5.err_over),  32'(ov));
      chk({tag, " err_under"}, 32'(if5.err_under), 32'(un));
    end else begin
      chk({tag, " count"},     32'(if123.count),     cnt);
      chk({tag, " full"},      32'(if123.full),      32'(f));
      chk({tag, " clear"},     32'(if123.clear),     32'(c));
      chk({tag, " err_over"},  32'(if123.err_over),  32'(ov));
      chk({tag, " err_under"}, 32'(if123.err_under), 32'(un));
    end
  endtask

  task automatic chk_digits(input string tag, input int d, input int h, input int t, input int o);
    if (d == 0) begin
      chk({tag, " hundreds"}, 32'(if5.hundreds), h);
      chk({tag, " tens"},     32'(if5.tens),     t);
      chk({tag, " ones"},     32'(if5.ones),     o);
    end else begin
      chk({tag, " hundreds"}, 32'(if123.hundreds), h);
      chk({tag, " tens"},     32'(if123.tens),     t);
      chk({tag, " ones"},     32'(if123.ones),     o);
    end
  endtask

  initial begin
    reset = 1'b1;
    if5.a_raw   = '0;
    if5.b_raw   = '0;
    if123.a_raw = '0;
    if123.b_raw = '0;

    // Values while reset is held.
    idle(3);
    chk_state("in_reset dut5", 0, 0, 0, 1, 0, 0);
    chk_state("in_reset dut123", 1, 0, 0, 1, 0, 0);
    chk_digits("in_reset dut5", 0, 0, 0, 0);
    chk("in_reset inc_evt", 32'(if5.inc_evt), 0);
    chk("in_reset dec_evt", 32'(if5.dec_evt), 0);

    reset = 1'b0;
    idle(10);
    chk_state("idle dut5", 0, 0, 0, 1, 0, 0);
    chk_digits("idle dut5", 0, 0, 0, 0);
    chk_digits("idle dut123", 1, 0, 0, 0);

    // Pedestrian: no overlap of the beams.
    seq_g0(0, 3, 12'b10_01_00_000000, 1'b0);
    idle(4);
    chk_state("pedestrian", 0, 0, 0, 1, 0, 0);

    // First entry, then fill the lot from gate 1.
    passage(0, 2'b01, 2'b00);
    idle(4);
    chk_state("entry1", 0, 1, 0, 0, 0, 0);
    repeat (4) passage(0, 2'b10, 2'b00);
    idle(4);
    chk_state("at_capacity", 0, 5, 1, 0, 0, 0);
    chk_digits("at_capacity", 0, 0, 0, 5);

    // Entry beyond capacity is dropped and flagged.
    passage(0, 2'b10, 2'b00);
    idle(4);
    chk_state("over_capacity", 0, 5, 1, 0, 1, 0);
    idle(6);
    chk("err_over sticky", 32'(if5.err_over), 1);

    // Same-cycle entry and exit cancel while full.
    passage(0, 2'b01, 2'b10);
    idle(4);
    chk_state("cancel_full", 0, 5, 1, 0, 1, 0);

    // Drain, then one exit too many.
    repeat (5) passage(0, 2'b00, 2'b10);
    idle(4);
    chk_state("drained", 0, 0, 0, 1, 1, 0);
    passage(0, 2'b00, 2'b01);
    idle(4);
    chk_state("under_zero", 0, 0, 0, 1, 1, 1);

    // Same-cycle entry and exit cancel while clear.
    passage(0, 2'b10, 2'b01);
    idle(4);
    chk_state("cancel_clear", 0, 0, 0, 1, 1, 1);

    // Reversals on both paths produce nothing.
    seq_g0(0, 4, 12'b10_11_10_00_0000, 1'b0);
    seq_g0(0, 4, 12'b01_11_01_00_0000, 1'b0);
    idle(4);
    chk_state("reversals", 0, 0, 0, 1, 1, 1);

    // Dithering between EN_AB and EN_B still completes one entry.
    seq_g0(0, 6, 12'b10_11_01_11_01_00, 1'b1);
    idle(4);
    chk_state("dither_entry", 0, 1, 0, 0, 1, 1);

    // Reset while the gate sits in EN_AB discards the passage.
    seq_g0(0, 2, 12'b10_11_00_00_00_00, 1'b0);
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    chk_state("after_mid_reset", 0, 0, 0, 1, 0, 0);
    seq_g0(0, 2, 12'b01_00_00_00_00_00, 1'b0);
    idle(6);
    chk_state("tail_after_reset", 0, 0, 0, 1, 0, 0);

    // CAPACITY=123 lot: two gates entering together, then one more.
    repeat (61) passage(1, 2'b11, 2'b00);
    idle(4);
    chk_state("lot123 at 122", 1, 122, 0, 0, 0, 0);
    chk_digits("lot123 at 122", 1, 1, 2, 2);
    passage(1, 2'b01, 2'b00);
    idle(4);
    chk_state("lot123 full", 1, 123, 1, 0, 0, 0);
    chk_digits("lot123 full", 1, 1, 2, 3);
    passage(1, 2'b10, 2'b00);
    idle(4);
    chk_state("lot123 over", 1, 123, 1, 0, 1, 0);

    idle(8);
    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
